// File: rtl/iram_port_arbiter.sv
// iram_port_arbiter: shares the single-port instruction RAM between
// the fetch unit (read-only) and the program loader (read/write).
// Ports: clk, reset (async, active-high);
//   fetch_req/fetch_addr -> fetch_done/fetch_instr;
//   ld_req/ld_we/ld_addr/ld_wdata -> ld_done/ld_rdata;
//   iram_address/iram_data/iram_read_not_write drive the RAM; busy.
// Build option: IRAM_ARB_LOADER_PRIORITY_EN gives the loader fixed
//   priority; otherwise simultaneous requests are round-robin.
`timescale 1ns/1ps

module iram_port_arbiter #(
  parameter int ADDRESS_BUS_WIDTH = 24,
  parameter int INSTRUCTION_WIDTH = 33
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_req,
  input  logic [ADDRESS_BUS_WIDTH-1:0] fetch_addr,
  output logic                         fetch_done,
  output logic [INSTRUCTION_WIDTH-1:0] fetch_instr,
  input  logic                         ld_req,
  input  logic                         ld_we,
  input  logic [ADDRESS_BUS_WIDTH-1:0] ld_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] ld_wdata,
  output logic                         ld_done,
  output logic [INSTRUCTION_WIDTH-1:0] ld_rdata,
  output logic [ADDRESS_BUS_WIDTH-1:0] iram_address,
  inout  wire  [INSTRUCTION_WIDTH-1:0] iram_data,
  output logic                         iram_read_not_write,
  output logic                         busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic                         req_any;
  logic                         pick_ld;
  logic                         owner_ld;
  logic                         we_q;
  logic [INSTRUCTION_WIDTH-1:0] wdata_q;

  assign req_any = fetch_req | ld_req;

`ifdef IRAM_ARB_LOADER_PRIORITY_EN
  always_comb begin
    pick_ld = ld_req;
  end
`else
  // rr_ld = 1: loader has the next turn on a tie.
  logic rr_ld;

  always_comb begin
    pick_ld = ld_req & (~fetch_req | rr_ld);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ld <= 1'b0;
    end else if (state == IDLE && req_any) begin
      rr_ld <= ~pick_ld;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_any) state_next = ACCESS;
      ACCESS:  state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_ld            <= 1'b0;
      we_q                <= 1'b0;
      wdata_q             <= '0;
      iram_address        <= '0;
      iram_read_not_write <= 1'b1;
      fetch_done          <= 1'b0;
      ld_done             <= 1'b0;
      fetch_instr         <= '0;
      ld_rdata            <= '0;
    end else begin
      fetch_done <= 1'b0;
      ld_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            owner_ld            <= pick_ld;
            we_q                <= pick_ld & ld_we;
            wdata_q             <= ld_wdata;
            iram_address        <= pick_ld ? ld_addr : fetch_addr;
            iram_read_not_write <= ~(pick_ld & ld_we);
          end
        end
        CAPTURE: begin
          // RAM read data registered at E1 is on the bus now.
          iram_read_not_write <= 1'b1;
          if (owner_ld) begin
            ld_done <= 1'b1;
            if (!we_q) ld_rdata <= iram_data;
          end else begin
            fetch_done  <= 1'b1;
            fetch_instr <= iram_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus is driven only for the single cycle the RAM samples a write.
  assign iram_data = (state == ACCESS && we_q) ?
                     wdata_q : {INSTRUCTION_WIDTH{1'bz}};

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_iram_port_arbiter.sv
// tb_iram_port_arbiter: directed table-driven bench for the arbiter
// with a behavioural single-port RAM (one-cycle registered read).
`timescale 1ns/1ps

module tb_iram_port_arbiter;

  localparam int AW = 24;
  localparam int IW = 33;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_done;
  logic [IW-1:0] fetch_instr;
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [IW-1:0] ld_wdata;
  logic          ld_done;
  logic [IW-1:0] ld_rdata;
  logic [AW-1:0] iram_address;
  wire  [IW-1:0] iram_data;
  logic          iram_read_not_write;
  logic          busy;

  iram_port_arbiter #(
    .ADDRESS_BUS_WIDTH(AW),
    .INSTRUCTION_WIDTH(IW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .fetch_req           (fetch_req),
    .fetch_addr          (fetch_addr),
    .fetch_done          (fetch_done),
    .fetch_instr         (fetch_instr),
    .ld_req              (ld_req),
    .ld_we               (ld_we),
    .ld_addr             (ld_addr),
    .ld_wdata            (ld_wdata),
    .ld_done             (ld_done),
    .ld_rdata            (ld_rdata),
    .iram_address        (iram_address),
    .iram_data           (iram_data),
    .iram_read_not_write (iram_read_not_write),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  // RAM model: 2K words, low address bits only (aliasing).
  // A write is taken on the first edge of a low read_not_write.
  logic [IW-1:0] mem [0:2047];
  logic [IW-1:0] ram_q = '0;
  logic          rnw_d = 1'b1;
  logic          pl_en = 1'b0;
  logic [10:0]   pl_a = '0;
  logic [IW-1:0] pl_d = '0;

  always @(posedge clk) begin
    rnw_d <= iram_read_not_write;
    if (pl_en)
      mem[pl_a] <= pl_d;
    else if (!iram_read_not_write && rnw_d)
      mem[iram_address[10:0]] <= iram_data;
    if (iram_read_not_write)
      ram_q <= mem[iram_address[10:0]];
  end

  assign iram_data = iram_read_not_write ? ram_q : {IW{1'bz}};

  int fd_cnt = 0;
  int ld_cnt = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (fetch_done) fd_cnt++;
    if (ld_done) ld_cnt++;
    if (fetch_done && ld_done) both_cnt++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic preload(input logic [10:0] a, input logic [IW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    fetch_req = 1'b0;
    ld_req    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit            is_ld;
    bit            we;
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } vec_t;

  vec_t tbl [9];
  logic [IW-1:0] last_f;
  logic [IW-1:0] last_l;

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit got;
    @(negedge clk);
    if (v.is_ld) begin
      ld_req   = 1'b1;
      ld_we    = v.we;
      ld_addr  = v.addr;
      ld_wdata = v.data;
    end else begin
      fetch_req  = 1'b1;
      fetch_addr = v.addr;
    end
    @(posedge clk);
    #1;
    lat = 1;
    chk($sformatf("v%0d busy", idx), 64'(busy), 64'd1);
    chk($sformatf("v%0d addr", idx), 64'(iram_address), 64'(v.addr));
    chk($sformatf("v%0d rnw", idx),
        64'(iram_read_not_write), 64'(!(v.is_ld && v.we)));
    if (v.is_ld && v.we)
      chk($sformatf("v%0d wbus", idx), 64'(iram_data), 64'(v.data));
    do begin
      @(posedge clk);
      #1;
      lat++;
      got = v.is_ld ? ld_done : fetch_done;
    end while (!got && lat < 12);
    fetch_req = 1'b0;
    ld_req    = 1'b0;
    chk($sformatf("v%0d latency", idx), 64'(lat), 64'd3);
    if (!v.we || !v.is_ld) begin
      if (v.is_ld) last_l = v.data;
      else last_f = v.data;
    end
    chk($sformatf("v%0d fetch_instr", idx), 64'(fetch_instr), 64'(last_f));
    chk($sformatf("v%0d ld_rdata", idx), 64'(ld_rdata), 64'(last_l));
  endtask

  initial begin : main
    int lat;
    int c0;
    bit [3:0] exp_seq;
    logic [IW-1:0] exp_d;

    tbl[0] = '{0, 0, 24'd1024,    33'h011000010};
    tbl[1] = '{1, 1, 24'd1026,    33'h052210000};
    tbl[2] = '{0, 0, 24'd1026,    33'h052210000};
    tbl[3] = '{1, 0, 24'd1024,    33'h011000010};
    tbl[4] = '{1, 1, 24'hFFFFFF,  33'h123456789};
    tbl[5] = '{0, 0, 24'h0007FF,  33'h123456789};
    tbl[6] = '{1, 0, 24'hFFFFFF,  33'h123456789};
    tbl[7] = '{1, 1, 24'd0,       33'h1FFFFFFFF};
    tbl[8] = '{0, 0, 24'd0,       33'h1FFFFFFFF};

    fetch_addr = '0;
    ld_we      = 1'b0;
    ld_addr    = '0;
    ld_wdata   = '0;
    last_f     = '0;
    last_l     = '0;
    do_reset();

    chk("rst busy", 64'(busy), 64'd0);
    chk("rst rnw", 64'(iram_read_not_write), 64'd1);
    chk("rst addr", 64'(iram_address), 64'd0);
    chk("rst fetch_done", 64'(fetch_done), 64'd0);
    chk("rst ld_done", 64'(ld_done), 64'd0);
    chk("rst fetch_instr", 64'(fetch_instr), 64'd0);
    chk("rst ld_rdata", 64'(ld_rdata), 64'd0);

    preload(11'd1024, 33'h011000010);
    preload(11'd1030, 33'h0AAAA5555);
    preload(11'd7,    33'h000000077);
    preload(11'd1025, 33'h000000000);

    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

    // Reset during the ACCESS cycle of a write.
    @(negedge clk);
    c0       = ld_cnt;
    ld_req   = 1'b1;
    ld_we    = 1'b1;
    ld_addr  = 24'd1030;
    ld_wdata = 33'h0DEADBEEF;
    @(posedge clk);
    #1;
    chk("rstw busy before", 64'(busy), 64'd1);
    reset  = 1'b1;
    ld_req = 1'b0;
    #1;
    chk("rstw busy", 64'(busy), 64'd0);
    chk("rstw rnw", 64'(iram_read_not_write), 64'd1);
    chk("rstw addr", 64'(iram_address), 64'd0);
    chk("rstw ld_rdata", 64'(ld_rdata), 64'd0);
    chk("rstw fetch_instr", 64'(fetch_instr), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstw mem kept", 64'(mem[1030]), 64'h0AAAA5555);
    chk("rstw no ld_done", 64'(ld_cnt - c0), 64'd0);
    last_f = '0;
    last_l = '0;

    // Fetch request dropped during ACCESS.
    @(negedge clk);
    c0         = fd_cnt;
    fetch_req  = 1'b1;
    fetch_addr = 24'd1024;
    @(posedge clk);
    #1;
    @(negedge clk);
    fetch_req = 1'b0;
    lat = 1;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!fetch_done && lat < 12);
    chk("drop latency", 64'(lat), 64'd3);
    chk("drop data", 64'(fetch_instr), 64'h011000010);
    @(posedge clk);
    #1;
    chk("drop idle busy", 64'(busy), 64'd0);
    chk("drop done low", 64'(fetch_done), 64'd0);
    @(negedge clk);
    chk("drop one pulse", 64'(fd_cnt - c0), 64'd1);

    // Loader inputs change after the grant edge.
    @(negedge clk);
    ld_req   = 1'b1;
    ld_we    = 1'b1;
    ld_addr  = 24'd1025;
    ld_wdata = 33'h10BADF00D;
    @(posedge clk);
    #1;
    @(negedge clk);
    ld_addr  = 24'd7;
    ld_wdata = 33'h055555555;
    ld_we    = 1'b0;
    lat = 1;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ld_done && lat < 12);
    ld_req = 1'b0;
    chk("late latency", 64'(lat), 64'd3);
    @(negedge clk);
    chk("late mem1025", 64'(mem[1025]), 64'h10BADF00D);
    chk("late mem7", 64'(mem[7]), 64'h000000077);

    // Contention from reset: four accesses with both requests held.
`ifdef IRAM_ARB_LOADER_PRIORITY_EN
    exp_seq = 4'b1111;
`else
    exp_seq = 4'b1010;
`endif
    do_reset();
    @(negedge clk);
    fetch_addr = 24'd1024;
    ld_we      = 1'b0;
    ld_addr    = 24'd1026;
    fetch_req  = 1'b1;
    ld_req     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!fetch_done && !ld_done && lat < 12);
      if (k == 3) begin
        fetch_req = 1'b0;
        ld_req    = 1'b0;
      end
      chk($sformatf("arb%0d latency", k), 64'(lat), 64'd3);
      chk($sformatf("arb%0d owner", k), 64'(ld_done), 64'(exp_seq[k]));
      exp_d = exp_seq[k] ? 33'h052210000 : 33'h011000010;
      chk($sformatf("arb%0d data", k),
          64'(ld_done ? ld_rdata : fetch_instr), 64'(exp_d));
    end
    repeat (4) @(negedge clk);
    chk("arb idle", 64'(busy), 64'd0);
    chk("dones exclusive", 64'(both_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
